// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller_pkg
// Purpose  : Shared definitions for the multicycle controller: FSM state
//            encoding, opcode and R-type function codes, ALU operation codes
//            and an opcode legality helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BEQEX  = 4'd10,
    S_BNEEX  = 4'd11,
    S_BLTEX  = 4'd12,
    S_JEX    = 4'd13
  } state_t;

  // Opcodes
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_SLTI  = 6'b001010;
  localparam logic [5:0] C_OP_LUI   = 6'b001111;
  localparam logic [5:0] C_OP_LI    = 6'b011001;
  localparam logic [5:0] C_OP_MIX   = 6'b011010;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_BLT   = 6'b000110;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;
  localparam logic [5:0] C_FN_NOR = 6'b100111;
  localparam logic [5:0] C_FN_SLL = 6'b000000;

  // ALU operation codes
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_BLT = 4'b0101;
  localparam logic [3:0] C_ALU_SLL = 4'b1000;
  localparam logic [3:0] C_ALU_LI  = 4'b1001;
  localparam logic [3:0] C_ALU_LUI = 4'b1011;
  localparam logic [3:0] C_ALU_NOR = 4'b1100;
  localparam logic [3:0] C_ALU_MIX = 4'b1110;

  // True when DECODE has somewhere to go for this opcode.
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      C_OP_RTYPE, C_OP_LW, C_OP_SW,
      C_OP_ADDI, C_OP_ANDI, C_OP_ORI, C_OP_SLTI, C_OP_LUI, C_OP_LI, C_OP_MIX,
      C_OP_BEQ, C_OP_BNE, C_OP_BLT, C_OP_J: op_legal = 1'b1;
      default:                              op_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_aludec.sv
`default_nettype none
// ============================================================================
// Module   : mc_aludec
// Purpose  : Combinational ALU operation decoder for the multicycle
//            controller. Selects the ALU code from the current state and,
//            in the execute states, from the opcode or R-type function field.
// Ports    : state      in  FSM state (already forced to FETCH under reset)
//            op         in  6  opcode
//            funct      in  6  R-type function
//            alucontrol out 4  ALU operation code
//            badfunct   out 1  R-type execute with an undecodable function
// Revision : 1.0 - initial release
// ============================================================================
module mc_aludec
  import mc_controller_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [3:0]  alucontrol,
  output logic        badfunct
);

  always_comb begin
    alucontrol = 4'b0000;
    badfunct   = 1'b0;
    case (state)
      // PC+4, branch target and effective address all use an add.
      S_FETCH, S_DECODE, S_MEMADR: alucontrol = C_ALU_ADD;
      S_REX: begin
        case (funct)
          C_FN_ADD: alucontrol = C_ALU_ADD;
          C_FN_SUB: alucontrol = C_ALU_SUB;
          C_FN_AND: alucontrol = C_ALU_AND;
          C_FN_OR:  alucontrol = C_ALU_OR;
          C_FN_SLT: alucontrol = C_ALU_SLT;
          C_FN_NOR: alucontrol = C_ALU_NOR;
          C_FN_SLL: alucontrol = C_ALU_SLL;
          default:  badfunct   = 1'b1;
        endcase
      end
      S_IEX: begin
        case (op)
          C_OP_ADDI: alucontrol = C_ALU_ADD;
          C_OP_ANDI: alucontrol = C_ALU_AND;
          C_OP_ORI:  alucontrol = C_ALU_OR;
          C_OP_SLTI: alucontrol = C_ALU_SLT;
          C_OP_LUI:  alucontrol = C_ALU_LUI;
          C_OP_LI:   alucontrol = C_ALU_LI;
          C_OP_MIX:  alucontrol = C_ALU_MIX;
          default:   alucontrol = 4'b0000;
        endcase
      end
      S_BEQEX, S_BNEEX: alucontrol = C_ALU_SUB;
      // The BLT ALU op yields zero when a < b, so zero=1 means taken.
      S_BLTEX:          alucontrol = C_ALU_BLT;
      default:          alucontrol = 4'b0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Purpose  : Moore-style multicycle CPU controller. Sequences fetch, decode,
//            memory, R-type, immediate, branch and jump instructions and
//            drives the datapath enables/selects.
// Ports    : clk        in  1  rising-edge clock
//            reset      in  1  synchronous active-low reset
//            op/funct   in  6  opcode / R-type function
//            zero       in  1  ALU zero flag
//            memready   in  1  memory ack for the current access
//            pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//            alusrca    out 1  datapath enables/selects
//            alusrcb    out 2  ALU B select; pcsrc out 2 PC source select
//            alucontrol out 4  ALU operation; illegal out 1 decode error pulse
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        memready,
  output logic        pcen,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [3:0]  alucontrol,
  output logic        illegal
);

  state_t r_state;
  state_t w_state;
  logic   w_badfunct;

  // While reset is low the outputs must already show FETCH values, even in
  // the cycle before the register has been forced, so decode from this.
  assign w_state = reset ? r_state : S_FETCH;

  mc_aludec u_aludec (
    .state      (w_state),
    .op         (op),
    .funct      (funct),
    .alucontrol (alucontrol),
    .badfunct   (w_badfunct)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (memready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            C_OP_LW, C_OP_SW: r_state <= S_MEMADR;
            C_OP_RTYPE:       r_state <= S_REX;
            C_OP_ADDI, C_OP_ANDI, C_OP_ORI, C_OP_SLTI,
            C_OP_LUI, C_OP_LI, C_OP_MIX: r_state <= S_IEX;
            C_OP_BEQ:         r_state <= S_BEQEX;
            C_OP_BNE:         r_state <= S_BNEEX;
            C_OP_BLT:         r_state <= S_BLTEX;
            C_OP_J:           r_state <= S_JEX;
            default:          r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (memready) r_state <= S_MEMWB;
        S_MEMWR:  if (memready) r_state <= S_FETCH;
        S_REX:    r_state <= w_badfunct ? S_FETCH : S_RWB;
        S_IEX:    r_state <= S_IWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pcen     = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    illegal  = 1'b0;
    case (w_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcen    = memready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_legal(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_REX: begin
        alusrca = 1'b1;
        illegal = w_badfunct;
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_IWB: regwrite = 1'b1;
      S_BEQEX: begin
        pcsrc = 2'b01;
        pcen  = zero;
      end
      S_BNEEX: begin
        pcsrc = 2'b01;
        pcen  = ~zero;
      end
      S_BLTEX: begin
        pcsrc = 2'b01;
        pcen  = zero;
      end
      S_JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: begin
        pcen = 1'b0;
      end
    endcase
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rise).
REQ-003 SHALL have ports: op  in  6  opcode; funct  in  6  R-type function; zero  in  1  ALU zero flag; memready  in  1  memory ack for current access.
REQ-004 SHALL have ports: pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath enables/selects.
REQ-005 SHALL have ports: alusrcb  out  2  (00 B, 01 const 4, 10 signimm, 11 signimm<<2); pcsrc  out  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-006 SHALL have ports: alucontrol  out  4  ALU operation code; illegal  out  1  one-cycle pulse on an undecodable instruction.

Function
REQ-007 SHALL be a Moore FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQEX, BNEEX, BLTEX, JEX.
REQ-008 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=0010, pcsrc=00; irwrite=1 and pc write only while memready=1; hold FETCH while memready=0; memready=1 -> DECODE.
REQ-009 DECODE: alusrca=0, alusrcb=11, alucontrol=0010 (branch target into ALUOut); next state by op.
REQ-010 Opcodes: lw 100011, sw 101011 -> MEMADR; R-type 000000 -> REX; addi 001000, andi 001100, ori 001101, slti 001010, lui 001111, li 011001, mix 011010 -> IEX; beq 000100 -> BEQEX; bne 000101 -> BNEEX; blt 000110 -> BLTEX; j 000010 -> JEX.
REQ-011 Any other op in DECODE: illegal=1 for that cycle, next state FETCH, no register/memory/PC write.
REQ-012 MEMADR: alusrca=1, alusrcb=10, alucontrol=0010; lw -> MEMRD, sw -> MEMWR.
REQ-013 MEMRD: iord=1; hold while memready=0; memready=1 -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
REQ-014 MEMWR: iord=1, memwrite=1; hold while memready=0; memready=1 -> FETCH.
REQ-015 REX: alusrca=1, alusrcb=00; funct map: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100, 000000->1000 (sll); unlisted funct -> illegal pulse, next FETCH, no RWB.
REQ-016 RWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-017 IEX: alusrca=1, alusrcb=10; addi 0010, andi 0000, ori 0001, slti 0111, lui 1011, li 1001, mix 1110 -> IWB. IWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-018 BEQEX: alucontrol=0110, pcsrc=01, pcen=zero. BNEEX: alucontrol=0110, pcsrc=01, pcen=~zero. BLTEX: alucontrol=0101, pcsrc=01, pcen=zero (ALU yields 0 when a<b). All -> FETCH.
REQ-019 JEX: pcsrc=10, pcen=1 -> FETCH.
REQ-020 pcen SHALL be combinational: (FETCH & memready) | JEX | branch-taken term; all other outputs depend only on state (plus op/funct for alucontrol).
REQ-021 Every output not listed for a state SHALL be 0 in that state; memwrite, regwrite, irwrite, pcen never asserted simultaneously with reset=0.
REQ-022 Latency (memready always 1): lw 5 cycles, sw 4, R-type/imm 4, branch 3, j 3, illegal 2.

Reset
REQ-023 reset=0 at a clk edge SHALL force state FETCH regardless of current state, including mid-access wait in MEMRD/MEMWR.
REQ-024 While reset=0, all write enables (pcen, irwrite, memwrite, regwrite) and illegal SHALL be 0; other outputs take FETCH values.
REQ-025 First cycle after reset release is FETCH; no in-flight instruction completes.

Structure
REQ-026 Shared package SHALL hold: state enum, opcode constants, funct constants, alucontrol codes (ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, BLT 0101, SLL 1000, LI 1001, LUI 1011, NOR 1100, MIX 1110).
REQ-027 Sub-module mc_aludec (combinational: state, op, funct -> alucontrol, illegal-funct flag) SHALL be instantiated once.

Verification
REQ-028 lw, memready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 with memtoreg=1 only in cycle 5.
REQ-029 sw with memready low 3 cycles in MEMWR -> memwrite held 4 cycles, single FETCH afterwards.
REQ-030 beq zero=1 -> pcen=1, pcsrc=01 in cycle 3; bne zero=1 -> pcen=0; blt zero=1 -> pcen=1.
REQ-031 R-type funct 100111 -> alucontrol=1100 in REX; funct 000000 -> 1000; funct 111111 -> illegal=1 one cycle, no regwrite.
REQ-032 op 111111 -> illegal pulse in DECODE, FETCH next, no writes.
REQ-033 reset=0 during MEMRD wait -> FETCH next cycle, all write enables 0 while reset low.
